// File: rtl/rvfpm_pkg.sv
// Shared opcode constants, FP-opcode decode and the buffered issue entry layout
// for the FPU issue buffer.
package rvfpm_pkg;

   localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
   localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
   localparam logic [6:0] OPC_MADD     = 7'b1000011;
   localparam logic [6:0] OPC_MSUB     = 7'b1000111;
   localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
   localparam logic [6:0] OPC_NMADD    = 7'b1001111;
   localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

   // Entry field widths; the top-level X_ID_WIDTH/XLEN defaults track these.
   localparam int unsigned ISSUE_ID_W = 4;
   localparam int unsigned ISSUE_XLEN = 32;

   typedef struct packed {
      logic [31:0]           instr;
      logic [ISSUE_ID_W-1:0] id;
      logic [ISSUE_XLEN-1:0] rs0;
   } issue_entry_t;

   function automatic logic is_fp(input logic [6:0] opc);
      logic fp;
      case (opc)
         OPC_LOAD_FP, OPC_STORE_FP, OPC_MADD, OPC_MSUB,
         OPC_NMSUB, OPC_NMADD, OPC_OP_FP: fp = 1'b1;
         default:                         fp = 1'b0;
      endcase
      return fp;
   endfunction

endpackage

// File: rtl/rvfpm_sync_fifo.sv
// Single-clock FIFO with registered pointers and count; flush clears all state
// and takes priority over push and pop.
module rvfpm_sync_fifo #(
   parameter type         T     = logic [7:0],
   parameter int unsigned DEPTH = 4
) (
   input  logic                     ck,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  T                         wdata,
   output T                         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW     = $clog2(DEPTH);
   localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);
   localparam logic [PW:0] ONE_C  = (PW+1)'(1);
   localparam logic [PW-1:0] INC_C = PW'(1);

   T              mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full    = (count_q == FULL_C);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push && !flush && !full;
   assign do_pop  = pop && !flush && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + INC_C;
         if (do_pop)  rd_ptr_d = rd_ptr_q + INC_C;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once count says they are valid.
   always_ff @(posedge ck) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/rvfpm_issue_buffer.sv
// Issue-side front end of the FPU model: decodes FP opcodes, buffers accepted
// instructions and dispatches one per cycle under fpu_ready throttling.
module rvfpm_issue_buffer
   import rvfpm_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned X_ID_WIDTH = ISSUE_ID_W,
   parameter int unsigned XLEN       = ISSUE_XLEN
) (
   input  logic                       ck,
   input  logic                       rst,
   input  logic                       issue_valid,
   output logic                       issue_ready,
   input  logic [31:0]                issue_instr,
   input  logic [X_ID_WIDTH-1:0]      issue_id,
   input  logic [XLEN-1:0]            issue_rs0,
   output logic                       issue_resp_accept,
   input  logic                       flush,
   input  logic                       fpu_ready,
   output logic                       fpu_enable,
   output logic [31:0]                fpu_instruction,
   output logic [X_ID_WIDTH-1:0]      fpu_id,
   output logic [XLEN-1:0]            fpu_data_fromXreg,
   output logic [$clog2(DEPTH):0]     occupancy
);

   issue_entry_t              wr_entry, head;
   logic                      full, empty, push, pop;
   logic                      fpu_enable_q, fpu_enable_d;
   logic [31:0]               fpu_instr_q, fpu_instr_d;
   logic [X_ID_WIDTH-1:0]     fpu_id_q, fpu_id_d;
   logic [XLEN-1:0]           fpu_data_q, fpu_data_d;

   assign issue_resp_accept = is_fp(issue_instr[6:0]);
   // Deliberately not qualified by a same-cycle pop: a full buffer refuses issue.
   assign issue_ready       = !rst && !flush && !full;
   assign push              = issue_valid && issue_ready && issue_resp_accept;
   assign pop               = !empty && fpu_ready && !flush;

   assign wr_entry.instr = issue_instr;
   assign wr_entry.id    = issue_id;
   assign wr_entry.rs0   = issue_rs0;

   rvfpm_sync_fifo #(
      .T     (issue_entry_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .ck    (ck),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (wr_entry),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (occupancy)
   );

   always_comb begin
      fpu_enable_d = pop;
      fpu_instr_d  = fpu_instr_q;
      fpu_id_d     = fpu_id_q;
      fpu_data_d   = fpu_data_q;
      if (pop) begin
         fpu_instr_d = head.instr;
         fpu_id_d    = head.id;
         fpu_data_d  = head.rs0;
      end
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         fpu_enable_q <= 1'b0;
         fpu_instr_q  <= '0;
         fpu_id_q     <= '0;
         fpu_data_q   <= '0;
      end else begin
         fpu_enable_q <= fpu_enable_d;
         fpu_instr_q  <= fpu_instr_d;
         fpu_id_q     <= fpu_id_d;
         fpu_data_q   <= fpu_data_d;
      end
   end

   assign fpu_enable        = fpu_enable_q;
   assign fpu_instruction   = fpu_instr_q;
   assign fpu_id            = fpu_id_q;
   assign fpu_data_fromXreg = fpu_data_q;

endmodule

// File: tb/tb_rvfpm_issue_buffer.sv
// Directed bench for rvfpm_issue_buffer: decode, latency, backpressure, ordering,
// flush and asynchronous reset.
module tb_rvfpm_issue_buffer;

   localparam logic [31:0] FP_INSTR = 32'h00A57053;
   localparam logic [31:0] OP_INSTR = 32'h00000033;

   logic        ck = 1'b0;
   logic        rst = 1'b1;
   logic        issue_valid = 1'b0;
   logic        issue_ready;
   logic [31:0] issue_instr = '0;
   logic [3:0]  issue_id = '0;
   logic [31:0] issue_rs0 = '0;
   logic        issue_resp_accept;
   logic        flush = 1'b0;
   logic        fpu_ready = 1'b0;
   logic        fpu_enable;
   logic [31:0] fpu_instruction;
   logic [3:0]  fpu_id;
   logic [31:0] fpu_data_fromXreg;
   logic [2:0]  occupancy;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 ck = ~ck;

   rvfpm_issue_buffer #(.DEPTH(4), .X_ID_WIDTH(4), .XLEN(32)) dut (
      .ck                (ck),
      .rst               (rst),
      .issue_valid       (issue_valid),
      .issue_ready       (issue_ready),
      .issue_instr       (issue_instr),
      .issue_id          (issue_id),
      .issue_rs0         (issue_rs0),
      .issue_resp_accept (issue_resp_accept),
      .flush             (flush),
      .fpu_ready         (fpu_ready),
      .fpu_enable        (fpu_enable),
      .fpu_instruction   (fpu_instruction),
      .fpu_id            (fpu_id),
      .fpu_data_fromXreg (fpu_data_fromXreg),
      .occupancy         (occupancy)
   );

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic drive_issue(input logic [31:0] instr, input logic [3:0] id, input logic [31:0] rs0);
      issue_valid = 1'b1;
      issue_instr = instr;
      issue_id    = id;
      issue_rs0   = rs0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      chk_cnt++; if (issue_ready !== 1'b0) $display("FAIL rst_ready got %0b want 0", issue_ready); else pass_cnt++;
      chk_cnt++; if (fpu_enable !== 1'b0) $display("FAIL rst_enable got %0b want 0", fpu_enable); else pass_cnt++;
      chk_cnt++; if (occupancy !== 3'd0) $display("FAIL rst_occ got %0d want 0", occupancy); else pass_cnt++;
      chk_cnt++; if (fpu_id !== 4'd0 || fpu_data_fromXreg !== 32'd0 || fpu_instruction !== 32'd0)
         $display("FAIL rst_payload got id=%0h data=%0h instr=%0h want 0", fpu_id, fpu_data_fromXreg, fpu_instruction);
      else pass_cnt++;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_latency();
      fpu_ready = 1'b1;
      drive_issue(FP_INSTR, 4'd3, 32'h1234);
      #1;
      chk_cnt++; if (issue_resp_accept !== 1'b1) $display("FAIL lat_accept got %0b want 1", issue_resp_accept); else pass_cnt++;
      chk_cnt++; if (issue_ready !== 1'b1) $display("FAIL lat_ready got %0b want 1", issue_ready); else pass_cnt++;
      tick();
      issue_valid = 1'b0;
      chk_cnt++; if (fpu_enable !== 1'b0) $display("FAIL lat_early_enable got %0b want 0", fpu_enable); else pass_cnt++;
      chk_cnt++; if (occupancy !== 3'd1) $display("FAIL lat_occ got %0d want 1", occupancy); else pass_cnt++;
      tick();
      chk_cnt++; if (fpu_enable !== 1'b1) $display("FAIL lat_enable got %0b want 1", fpu_enable); else pass_cnt++;
      chk_cnt++; if (fpu_id !== 4'd3) $display("FAIL lat_id got %0d want 3", fpu_id); else pass_cnt++;
      chk_cnt++; if (fpu_data_fromXreg !== 32'h1234) $display("FAIL lat_data got %0h want 1234", fpu_data_fromXreg); else pass_cnt++;
      chk_cnt++; if (fpu_instruction !== FP_INSTR) $display("FAIL lat_instr got %0h want %0h", fpu_instruction, FP_INSTR); else pass_cnt++;
      tick();
      chk_cnt++; if (fpu_enable !== 1'b0) $display("FAIL lat_single_pulse got %0b want 0", fpu_enable); else pass_cnt++;
   endtask

   task automatic test_reject();
      drive_issue(OP_INSTR, 4'd9, 32'h55);
      #1;
      chk_cnt++; if (issue_resp_accept !== 1'b0) $display("FAIL rej_accept got %0b want 0", issue_resp_accept); else pass_cnt++;
      chk_cnt++; if (issue_ready !== 1'b1) $display("FAIL rej_ready got %0b want 1", issue_ready); else pass_cnt++;
      tick();
      issue_valid = 1'b0;
      chk_cnt++; if (occupancy !== 3'd0) $display("FAIL rej_occ got %0d want 0", occupancy); else pass_cnt++;
      tick();
      chk_cnt++; if (fpu_enable !== 1'b0) $display("FAIL rej_enable got %0b want 0", fpu_enable); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      fpu_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_issue(FP_INSTR, 4'(i), 32'h100 + 32'(i));
         #1;
         chk_cnt++;
         if (issue_ready !== (i < 4)) $display("FAIL bp_ready_%0d got %0b want %0b", i, issue_ready, (i < 4));
         else pass_cnt++;
         tick();
      end
      issue_valid = 1'b0;
      chk_cnt++; if (occupancy !== 3'd4) $display("FAIL bp_occ got %0d want 4", occupancy); else pass_cnt++;
      fpu_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_cnt++; if (fpu_enable !== 1'b1) $display("FAIL bp_enable_%0d got %0b want 1", k, fpu_enable); else pass_cnt++;
         chk_cnt++; if (fpu_id !== 4'(k)) $display("FAIL bp_id_%0d got %0d want %0d", k, fpu_id, k); else pass_cnt++;
         chk_cnt++; if (fpu_data_fromXreg !== 32'h100 + 32'(k))
            $display("FAIL bp_data_%0d got %0h want %0h", k, fpu_data_fromXreg, 32'h100 + 32'(k));
         else pass_cnt++;
      end
      tick();
      chk_cnt++; if (fpu_enable !== 1'b0) $display("FAIL bp_drain_enable got %0b want 0", fpu_enable); else pass_cnt++;
      chk_cnt++; if (occupancy !== 3'd0) $display("FAIL bp_drain_occ got %0d want 0", occupancy); else pass_cnt++;
   endtask

   task automatic test_push_pop();
      fpu_ready = 1'b0;
      drive_issue(FP_INSTR, 4'd5, 32'h205);
      tick();
      drive_issue(FP_INSTR, 4'd6, 32'h206);
      tick();
      issue_valid = 1'b0;
      chk_cnt++; if (occupancy !== 3'd2) $display("FAIL pp_pre_occ got %0d want 2", occupancy); else pass_cnt++;
      fpu_ready = 1'b1;
      drive_issue(FP_INSTR, 4'd7, 32'h207);
      tick();
      issue_valid = 1'b0;
      chk_cnt++; if (occupancy !== 3'd2) $display("FAIL pp_occ got %0d want 2", occupancy); else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick();
         chk_cnt++; if (fpu_enable !== 1'b1 || fpu_id !== 4'(5 + k))
            $display("FAIL pp_order_%0d got en=%0b id=%0d want en=1 id=%0d", k, fpu_enable, fpu_id, 5 + k);
         else pass_cnt++;
      end
      tick();
      chk_cnt++; if (fpu_enable !== 1'b0) $display("FAIL pp_drain got %0b want 0", fpu_enable); else pass_cnt++;
   endtask

   task automatic test_flush();
      fpu_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_issue(FP_INSTR, 4'(8 + i), 32'h300 + 32'(i));
         tick();
      end
      issue_valid = 1'b0;
      chk_cnt++; if (occupancy !== 3'd3) $display("FAIL fl_pre_occ got %0d want 3", occupancy); else pass_cnt++;
      flush = 1'b1;
      fpu_ready = 1'b1;
      drive_issue(FP_INSTR, 4'd11, 32'h30B);
      #1;
      chk_cnt++; if (issue_ready !== 1'b0) $display("FAIL fl_ready got %0b want 0", issue_ready); else pass_cnt++;
      tick();
      flush = 1'b0;
      issue_valid = 1'b0;
      chk_cnt++; if (occupancy !== 3'd0) $display("FAIL fl_occ got %0d want 0", occupancy); else pass_cnt++;
      chk_cnt++; if (fpu_enable !== 1'b0) $display("FAIL fl_enable got %0b want 0", fpu_enable); else pass_cnt++;
      chk_cnt++; if (fpu_id !== 4'd7) $display("FAIL fl_payload_hold got %0d want 7", fpu_id); else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_cnt++; if (fpu_enable !== 1'b0) $display("FAIL fl_stale_%0d got %0b want 0", k, fpu_enable); else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      fpu_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_issue(FP_INSTR, 4'(12 + i), 32'h400 + 32'(i));
         tick();
      end
      issue_valid = 1'b0;
      fpu_ready = 1'b1;
      tick();
      chk_cnt++; if (fpu_enable !== 1'b1 || fpu_id !== 4'd12)
         $display("FAIL ar_pre got en=%0b id=%0d want en=1 id=12", fpu_enable, fpu_id);
      else pass_cnt++;
      chk_cnt++; if (occupancy !== 3'd3) $display("FAIL ar_pre_occ got %0d want 3", occupancy); else pass_cnt++;
      #3;
      rst = 1'b1;
      #1;
      chk_cnt++; if (fpu_enable !== 1'b0) $display("FAIL ar_enable got %0b want 0", fpu_enable); else pass_cnt++;
      chk_cnt++; if (occupancy !== 3'd0) $display("FAIL ar_occ got %0d want 0", occupancy); else pass_cnt++;
      chk_cnt++; if (issue_ready !== 1'b0) $display("FAIL ar_ready got %0b want 0", issue_ready); else pass_cnt++;
      chk_cnt++; if (fpu_id !== 4'd0) $display("FAIL ar_id got %0d want 0", fpu_id); else pass_cnt++;
      tick();
      #2;
      rst = 1'b0;
      tick();
      chk_cnt++; if (fpu_enable !== 1'b0) $display("FAIL ar_no_stale got %0b want 0", fpu_enable); else pass_cnt++;
      drive_issue(FP_INSTR, 4'd6, 32'hBEEF);
      tick();
      issue_valid = 1'b0;
      chk_cnt++; if (fpu_enable !== 1'b0) $display("FAIL ar_new_early got %0b want 0", fpu_enable); else pass_cnt++;
      tick();
      chk_cnt++; if (fpu_enable !== 1'b1 || fpu_id !== 4'd6 || fpu_data_fromXreg !== 32'hBEEF)
         $display("FAIL ar_new got en=%0b id=%0d data=%0h want en=1 id=6 data=beef", fpu_enable, fpu_id, fpu_data_fromXreg);
      else pass_cnt++;
      tick();
      chk_cnt++; if (fpu_enable !== 1'b0) $display("FAIL ar_new_single got %0b want 0", fpu_enable); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_reject();
      test_backpressure();
      test_push_pop();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
